// File: rtl/poker_pkg.sv
// Shared types and constants for the poker round controller and the add-ten stage.
package poker_pkg;

   localparam int unsigned CHIP_W    = 8;
   localparam int unsigned CARD_W    = 4;
   localparam int unsigned ANTE_DEF  = 10;
   localparam int unsigned RAISE_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ANTE,
      ST_BET,
      ST_SHOWDOWN,
      ST_SETTLE,
      ST_OVER
   } state_e;

   typedef enum logic [1:0] {
      LG_NONE,
      LG_ANTE,
      LG_MOVE,
      LG_PAY
   } ledger_op_e;

   // One chip-ledger command: what to do, which player, how many chips.
   typedef struct packed {
      ledger_op_e          op;
      logic                side;
      logic [CHIP_W-1:0]   amt;
   } ledger_cmd_t;

   localparam logic [1:0] ACT_CALL  = 2'b00;
   localparam logic [1:0] ACT_RAISE = 2'b01;
   localparam logic [1:0] ACT_FOLD  = 2'b10;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_A     = 2'b01;
   localparam logic [1:0] WIN_B     = 2'b10;
   localparam logic [1:0] WIN_SPLIT = 2'b11;

   // Higher card wins; equal cards split.
   function automatic logic [1:0] card_winner(input logic [CARD_W-1:0] a,
                                              input logic [CARD_W-1:0] b);
      if (a > b)      return WIN_A;
      else if (b > a) return WIN_B;
      else            return WIN_SPLIT;
   endfunction

endpackage

// File: rtl/poker_round_ctrl_if.sv
// Player-facing handshake and status bus of the poker round controller.
interface poker_round_ctrl_if;
   import poker_pkg::*;

   logic                start;
   logic [CARD_W-1:0]   card_a;
   logic [CARD_W-1:0]   card_b;
   logic                act_valid;
   logic [1:0]          act;
   logic                act_ready;
   logic                turn;
   logic [CHIP_W-1:0]   chips_a;
   logic [CHIP_W-1:0]   chips_b;
   logic [CHIP_W-1:0]   pot;
   logic [CHIP_W-1:0]   bet_a;
   logic [CHIP_W-1:0]   bet_b;
   logic [CHIP_W-1:0]   raise_b;
   logic                raise_s;
   logic [1:0]          winner;
   logic                done;
   logic                game_over;

   modport master (
      output start, card_a, card_b, act_valid, act,
      input  act_ready, turn, chips_a, chips_b, pot, bet_a, bet_b,
             raise_b, raise_s, winner, done, game_over
   );

   modport slave (
      input  start, card_a, card_b, act_valid, act,
      output act_ready, turn, chips_a, chips_b, pot, bet_a, bet_b,
             raise_b, raise_s, winner, done, game_over
   );

endinterface

// File: rtl/poker_round_ctrl_chip_ledger.sv
// Stack, bet and pot registers; every chip movement keeps stacks + pot constant.
module chip_ledger
   import poker_pkg::*;
#(
   parameter int unsigned INIT_CHIPS = 100,
   parameter int unsigned ANTE       = ANTE_DEF
)(
   input  logic                clk,
   input  logic                rst,
   input  ledger_cmd_t         i_cmd,
   input  logic [1:0]          i_winner,
   output logic [CHIP_W-1:0]   o_chips_a,
   output logic [CHIP_W-1:0]   o_chips_b,
   output logic [CHIP_W-1:0]   o_pot,
   output logic [CHIP_W-1:0]   o_bet_a,
   output logic [CHIP_W-1:0]   o_bet_b
);

   logic [CHIP_W-1:0] r_chips_a;
   logic [CHIP_W-1:0] r_chips_b;
   logic [CHIP_W-1:0] r_pot;
   logic [CHIP_W-1:0] r_bet_a;
   logic [CHIP_W-1:0] r_bet_b;
   logic [CHIP_W-1:0] w_half;

   // Split pots are always even because both bets are equal at showdown.
   assign w_half = r_pot >> 1;

   // Apply the FSM's ledger command on each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chips_a <= CHIP_W'(INIT_CHIPS);
         r_chips_b <= CHIP_W'(INIT_CHIPS);
         r_pot     <= '0;
         r_bet_a   <= '0;
         r_bet_b   <= '0;
      end else begin
         case (i_cmd.op)
            LG_ANTE: begin
               r_chips_a <= r_chips_a - CHIP_W'(ANTE);
               r_chips_b <= r_chips_b - CHIP_W'(ANTE);
               r_bet_a   <= CHIP_W'(ANTE);
               r_bet_b   <= CHIP_W'(ANTE);
               r_pot     <= CHIP_W'(2 * ANTE);
            end
            LG_MOVE: begin
               if (i_cmd.side) begin
                  r_chips_b <= r_chips_b - i_cmd.amt;
                  r_bet_b   <= r_bet_b + i_cmd.amt;
               end else begin
                  r_chips_a <= r_chips_a - i_cmd.amt;
                  r_bet_a   <= r_bet_a + i_cmd.amt;
               end
               r_pot <= r_pot + i_cmd.amt;
            end
            LG_PAY: begin
               case (i_winner)
                  WIN_A:     r_chips_a <= r_chips_a + r_pot;
                  WIN_B:     r_chips_b <= r_chips_b + r_pot;
                  WIN_SPLIT: begin
                     r_chips_a <= r_chips_a + w_half;
                     r_chips_b <= r_chips_b + w_half;
                  end
                  default: ;
               endcase
               r_pot   <= '0;
               r_bet_a <= '0;
               r_bet_b <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_chips_a = r_chips_a;
   assign o_chips_b = r_chips_b;
   assign o_pot     = r_pot;
   assign o_bet_a   = r_bet_a;
   assign o_bet_b   = r_bet_b;

endmodule

// File: rtl/poker_round_ctrl.sv
// Round controller for one Indian Poker hand: antes, alternating betting, settlement.
module poker_round_ctrl
   import poker_pkg::*;
#(
   parameter int unsigned INIT_CHIPS = 100,
   parameter int unsigned ANTE       = ANTE_DEF,
   parameter int unsigned RAISE      = RAISE_DEF,
   parameter int unsigned MAX_RAISES = 4
)(
   input  logic                clk,
   input  logic                rst,
   poker_round_ctrl_if.slave   bus
);

   localparam int unsigned CNT_W = 3;

   state_e              r_state;
   logic [CARD_W-1:0]   r_card_a;
   logic [CARD_W-1:0]   r_card_b;
   logic [CNT_W-1:0]    r_raise_cnt;
   logic [1:0]          r_act_cnt;
   logic                r_turn;
   logic                r_act_ready;
   logic [CHIP_W-1:0]   r_raise_b;
   logic                r_raise_s;
   logic [1:0]          r_winner;
   logic                r_done;
   logic                r_game_over;

   logic [CHIP_W-1:0]   w_chips_a;
   logic [CHIP_W-1:0]   w_chips_b;
   logic [CHIP_W-1:0]   w_pot;
   logic [CHIP_W-1:0]   w_bet_a;
   logic [CHIP_W-1:0]   w_bet_b;
   logic [CHIP_W-1:0]   w_own_bet;
   logic [CHIP_W-1:0]   w_opp_bet;
   logic [CHIP_W-1:0]   w_own_chips;
   logic [CHIP_W-1:0]   w_opp_chips;
   logic [CHIP_W-1:0]   w_diff;
   logic                w_accept;
   logic                w_is_fold;
   logic                w_is_raise;
   logic                w_raise_ok;
   ledger_cmd_t         w_cmd;

   // Actor-relative view of the bets/stacks and the raise legality check.
   always_comb begin
      w_own_bet   = r_turn ? w_bet_b   : w_bet_a;
      w_opp_bet   = r_turn ? w_bet_a   : w_bet_b;
      w_own_chips = r_turn ? w_chips_b : w_chips_a;
      w_opp_chips = r_turn ? w_chips_a : w_chips_b;
      w_diff      = w_opp_bet - w_own_bet;
      w_raise_ok  = (r_raise_cnt < CNT_W'(MAX_RAISES)) &&
                    ({1'b0, w_own_chips} >= ({1'b0, w_diff} + 9'(RAISE))) &&
                    (w_opp_chips >= CHIP_W'(RAISE));
      w_accept    = r_act_ready && bus.act_valid;
      w_is_fold   = (bus.act == ACT_FOLD);
      w_is_raise  = (bus.act == ACT_RAISE) && w_raise_ok;
   end

   // Ledger command for this cycle; illegal raises and code 11 move like a call.
   always_comb begin
      w_cmd.op   = LG_NONE;
      w_cmd.side = r_turn;
      w_cmd.amt  = '0;
      case (r_state)
         ST_ANTE:   w_cmd.op = LG_ANTE;
         ST_BET: begin
            if (w_accept && !w_is_fold) begin
               w_cmd.op  = LG_MOVE;
               w_cmd.amt = w_is_raise ? (w_diff + CHIP_W'(RAISE)) : w_diff;
            end
         end
         ST_SETTLE: w_cmd.op = LG_PAY;
         default: ;
      endcase
   end

   // Hand sequencing FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_card_a    <= '0;
         r_card_b    <= '0;
         r_raise_cnt <= '0;
         r_act_cnt   <= '0;
         r_turn      <= 1'b0;
         r_act_ready <= 1'b0;
         r_raise_b   <= '0;
         r_raise_s   <= 1'b0;
         r_winner    <= WIN_NONE;
         r_done      <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_raise_s <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  if ((w_chips_a < CHIP_W'(ANTE)) || (w_chips_b < CHIP_W'(ANTE))) begin
                     r_game_over <= 1'b1;
                     r_state     <= ST_OVER;
                  end else begin
                     r_card_a <= bus.card_a;
                     r_card_b <= bus.card_b;
                     r_state  <= ST_ANTE;
                  end
               end
            end
            ST_ANTE: begin
               r_raise_cnt <= '0;
               r_act_cnt   <= '0;
               r_turn      <= 1'b0;
               r_winner    <= WIN_NONE;
               r_act_ready <= 1'b1;
               r_state     <= ST_BET;
            end
            ST_BET: begin
               if (w_accept) begin
                  if (r_act_cnt != 2'd3) r_act_cnt <= r_act_cnt + 2'd1;
                  if (w_is_fold) begin
                     r_winner    <= r_turn ? WIN_A : WIN_B;
                     r_act_ready <= 1'b0;
                     r_state     <= ST_SETTLE;
                  end else if (w_is_raise) begin
                     r_raise_b   <= w_opp_bet;
                     r_raise_s   <= 1'b1;
                     r_raise_cnt <= r_raise_cnt + CNT_W'(1);
                     r_turn      <= ~r_turn;
                  end else if (r_act_cnt != 2'd0) begin
                     r_act_ready <= 1'b0;
                     r_state     <= ST_SHOWDOWN;
                  end else begin
                     r_turn <= ~r_turn;
                  end
               end
            end
            ST_SHOWDOWN: begin
               r_winner <= card_winner(r_card_a, r_card_b);
               r_state  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            ST_OVER: r_state <= ST_OVER;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   chip_ledger #(
      .INIT_CHIPS (INIT_CHIPS),
      .ANTE       (ANTE)
   ) u_ledger (
      .clk        (clk),
      .rst        (rst),
      .i_cmd      (w_cmd),
      .i_winner   (r_winner),
      .o_chips_a  (w_chips_a),
      .o_chips_b  (w_chips_b),
      .o_pot      (w_pot),
      .o_bet_a    (w_bet_a),
      .o_bet_b    (w_bet_b)
   );

   assign bus.act_ready = r_act_ready;
   assign bus.turn      = r_turn;
   assign bus.chips_a   = w_chips_a;
   assign bus.chips_b   = w_chips_b;
   assign bus.pot       = w_pot;
   assign bus.bet_a     = w_bet_a;
   assign bus.bet_b     = w_bet_b;
   assign bus.raise_b   = r_raise_b;
   assign bus.raise_s   = r_raise_s;
   assign bus.winner    = r_winner;
   assign bus.done      = r_done;
   assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_poker_round_ctrl.sv
// Scoreboard bench for poker_round_ctrl against a per-hand reference model.
module tb_poker_round_ctrl;
   import poker_pkg::*;

   localparam int INIT  = 100;
   localparam int ANT   = 10;
   localparam int RSE   = 10;
   localparam int MAXR  = 4;

   typedef struct {
      int w;
      int a;
      int b;
   } exp_done_t;

   logic clk;
   logic rst;
   poker_round_ctrl_if bus();

   poker_round_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int        n_vec = 0;
   int        n_err = 0;
   int        n_rs  = 0;
   bit        mon_en = 0;
   int        q_raise[$];
   exp_done_t q_done[$];

   int m_a, m_b;
   bit m_over;
   int h_acts[12];
   int m_pot[12];
   int m_rs[12];
   int m_turn[12];

   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: conservation every cycle, raise and settlement events against the queues.
   initial begin
      exp_done_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("conservation", int'(bus.chips_a) + int'(bus.chips_b) + int'(bus.pot), 2 * INIT);
            if (bus.raise_s) begin
               n_rs++;
               if (q_raise.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL raise_s: unexpected pulse, raise_b=%0d", bus.raise_b);
               end else chk("raise_b", int'(bus.raise_b), q_raise.pop_front());
            end
            if (bus.done) begin
               if (q_done.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL done: unexpected pulse, winner=%0d", bus.winner);
               end else begin
                  e = q_done.pop_front();
                  chk("winner", int'(bus.winner), e.w);
                  chk("settle_chips_a", int'(bus.chips_a), e.a);
                  chk("settle_chips_b", int'(bus.chips_b), e.b);
                  chk("settle_pot", int'(bus.pot), 0);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: play the hand from the betting rules on whole stacks and bets.
   task automatic model_hand(input int ca, input int cb,
                             output int n_used, output bit over, output bit folded);
      int stk[2];
      int bet[2];
      int p, o, diff, raises, win;
      bit ended;
      exp_done_t e;
      n_used = 0; over = 0; folded = 0;
      stk[0] = m_a; stk[1] = m_b;
      if (m_over || stk[0] < ANT || stk[1] < ANT) begin
         m_over = 1; over = 1;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         stk[i] -= ANT;
         bet[i] = ANT;
      end
      p = 0; raises = 0; win = 2; ended = 0;
      while (!ended && n_used < 12) begin
         o = 1 - p;
         diff = bet[o] - bet[p];
         m_turn[n_used] = p;
         m_rs[n_used] = 0;
         if (h_acts[n_used] == 2) begin
            win = o; folded = 1; ended = 1;
         end else if (h_acts[n_used] == 1 && raises < MAXR &&
                      stk[p] >= diff + RSE && stk[o] >= RSE) begin
            q_raise.push_back(bet[o]);
            stk[p] -= diff + RSE;
            bet[p] = bet[o] + RSE;
            raises++;
            m_rs[n_used] = 1;
            p = o;
         end else begin
            stk[p] -= diff;
            bet[p] = bet[o];
            if (n_used >= 1) begin
               ended = 1;
               win = (ca > cb) ? 0 : ((cb > ca) ? 1 : 2);
            end else p = o;
         end
         m_pot[n_used] = bet[0] + bet[1];
         n_used++;
      end
      if (win < 2) stk[win] += bet[0] + bet[1];
      else begin
         stk[0] += (bet[0] + bet[1]) / 2;
         stk[1] += (bet[0] + bet[1]) / 2;
      end
      e.w = win + 1; e.a = stk[0]; e.b = stk[1];
      q_done.push_back(e);
      m_a = stk[0]; m_b = stk[1];
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; bus.start = 1'b0; bus.act_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_chips_a", int'(bus.chips_a), INIT);
      chk("rst_chips_b", int'(bus.chips_b), INIT);
      chk("rst_pot", int'(bus.pot), 0);
      chk("rst_bet_a", int'(bus.bet_a), 0);
      chk("rst_bet_b", int'(bus.bet_b), 0);
      chk("rst_act_ready", int'(bus.act_ready), 0);
      chk("rst_game_over", int'(bus.game_over), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_winner", int'(bus.winner), 0);
      chk("rst_raise_s", int'(bus.raise_s), 0);
      rst = 1'b0;
      m_a = INIT; m_b = INIT; m_over = 0;
      q_raise.delete(); q_done.delete();
      mon_en = 1;
   endtask

   // Drive one hand from h_acts[]; direct checks cover timing, the monitor covers results.
   task automatic play_hand(input int ca, input int cb);
      int n_used, k;
      bit over, folded;
      model_hand(ca, cb, n_used, over, folded);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.card_a = 4'(ca); bus.card_b = 4'(cb);
      @(posedge clk); #1;
      bus.start = 1'($urandom_range(1, 0));
      bus.card_a = 4'($urandom_range(10, 1));
      bus.act_valid = 1'b1; bus.act = ACT_FOLD;
      if (over) begin
         chk("game_over", int'(bus.game_over), 1);
         chk("over_act_ready", int'(bus.act_ready), 0);
         @(posedge clk); #1;
         bus.start = 1'b0; bus.act_valid = 1'b0;
         chk("over_sticky", int'(bus.game_over), 1);
         chk("over_act_ready_hold", int'(bus.act_ready), 0);
         return;
      end
      chk("ante_act_ready", int'(bus.act_ready), 0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.act_valid = 1'b0;
      chk("start_to_ready", int'(bus.act_ready), 1);
      chk("ante_pot", int'(bus.pot), 2 * ANT);
      for (int i = 0; i < n_used; i++) begin
         chk("turn", int'(bus.turn), m_turn[i]);
         bus.act_valid = 1'b1; bus.act = 2'(h_acts[i]);
         @(posedge clk); #1;
         bus.act_valid = 1'b0;
         chk("pot_after_act", int'(bus.pot), m_pot[i]);
         chk("raise_s_timing", int'(bus.raise_s), m_rs[i]);
      end
      k = 0;
      while (!bus.done && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_latency", k, folded ? 1 : 2);
      chk("idle_act_ready", int'(bus.act_ready), 0);
   endtask

   initial begin
      int rs0, guard;
      rst = 1'b1;
      bus.start = 1'b0; bus.card_a = '0; bus.card_b = '0;
      bus.act_valid = 1'b0; bus.act = '0;
      m_a = INIT; m_b = INIT; m_over = 0;
      repeat (2) @(posedge clk);
      do_reset();

      // A 7 vs B 3, check/call to showdown.
      h_acts[0] = 0; h_acts[1] = 0;
      play_hand(7, 3);
      chk("t1_chips_a", int'(bus.chips_a), 110);
      chk("t1_chips_b", int'(bus.chips_b), 90);

      // A raises, B folds.
      do_reset();
      rs0 = n_rs;
      h_acts[0] = 1; h_acts[1] = 2;
      play_hand(7, 3);
      chk("t2_raise_count", n_rs - rs0, 1);
      chk("t2_chips_a", int'(bus.chips_a), 110);
      chk("t2_chips_b", int'(bus.chips_b), 90);

      // Equal cards split the pot.
      do_reset();
      h_acts[0] = 1; h_acts[1] = 0;
      play_hand(5, 5);
      chk("t3_chips_a", int'(bus.chips_a), 100);
      chk("t3_chips_b", int'(bus.chips_b), 100);
      chk("t3_pot", int'(bus.pot), 0);

      // Fifth raise exceeds the limit and becomes the showdown call.
      do_reset();
      rs0 = n_rs;
      for (int i = 0; i < 5; i++) h_acts[i] = 1;
      play_hand(2, 9);
      chk("t4_raise_count", n_rs - rs0, 4);
      chk("t4_chips_b", int'(bus.chips_b), 150);

      // A folds every hand until broke; the next start ends the game.
      do_reset();
      h_acts[0] = 2;
      guard = 0;
      while (!m_over && guard < 20) begin
         play_hand(int'($urandom_range(10, 1)), int'($urandom_range(10, 1)));
         guard++;
      end
      chk("t5_chips_a", int'(bus.chips_a), 0);
      chk("t5_hands", guard, 11);

      // Reset in the middle of betting discards the pot.
      do_reset();
      @(posedge clk); #1;
      bus.start = 1'b1; bus.card_a = 4'd7; bus.card_b = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      q_raise.push_back(10);
      q_raise.push_back(20);
      bus.act_valid = 1'b1; bus.act = ACT_RAISE;
      @(posedge clk); #1;
      bus.act = ACT_RAISE;
      @(posedge clk); #1;
      bus.act_valid = 1'b0;
      chk("t6_pot_before_rst", int'(bus.pot), 50);
      do_reset();

      // Randomised hands.
      for (int h = 0; h < 40; h++) begin
         if (m_over) do_reset();
         for (int i = 0; i < 12; i++) h_acts[i] = int'($urandom_range(3, 0));
         play_hand(int'($urandom_range(10, 1)), int'($urandom_range(10, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("raise_queue_drained", q_raise.size(), 0);
      chk("done_queue_drained", q_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
